// File: rtl/ibex_pkg.sv
// Shared types for the multdiv issue/response controller.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_CTRL_IDLE  = 2'd0,
    MD_CTRL_BUSY  = 2'd1,
    MD_CTRL_DRAIN = 2'd2,
    MD_CTRL_RESP  = 2'd3
  } md_ctrl_state_e;

  // DIV and REM share the divider; both multiply ops use the multiplier.
  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/ibex_multdiv_result_cache.sv
// Single-entry result cache keyed by {operator, signed_mode, op_a, op_b}.
// Only compiled when MULTDIV_CTRL_RESULT_CACHE_EN is defined.
`ifdef MULTDIV_CTRL_RESULT_CACHE_EN
module ibex_multdiv_result_cache (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fill_i,
  input  logic [67:0] fill_key_i,
  input  logic [31:0] fill_result_i,
  input  logic [67:0] lookup_key_i,
  output logic        hit_o,
  output logic [31:0] hit_result_o
);

  logic        valid_q;
  logic [67:0] key_q;
  logic [31:0] result_q;

  // Valid bit is only ever cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      key_q    <= 68'd0;
      result_q <= 32'd0;
    end else if (fill_i) begin
      valid_q  <= 1'b1;
      key_q    <= fill_key_i;
      result_q <= fill_result_i;
    end else begin
      valid_q  <= valid_q;
      key_q    <= key_q;
      result_q <= result_q;
    end
  end

  assign hit_o        = valid_q & (key_q == lookup_key_i);
  assign hit_result_o = result_q;

endmodule
`endif

// File: rtl/ibex_multdiv_ctrl.sv
// Issue/response controller in front of ibex_multdiv_fast.
// Optional single-entry result cache: define MULTDIV_CTRL_RESULT_CACHE_EN.
module ibex_multdiv_ctrl
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_operator_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic        kill_i,
  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output logic [1:0]  md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        busy_o
);

  md_ctrl_state_e state_q, state_d;
  md_op_e         op_q;
  logic [1:0]     sm_q;
  logic [31:0]    a_q, b_q, result_q;
  logic           accept, capture, md_en;
  logic           cache_hit;
  logic [31:0]    cache_result;

  assign accept  = (state_q == MD_CTRL_IDLE) & req_valid_i & ~kill_i;
  assign capture = (state_q == MD_CTRL_BUSY) & md_valid_i & ~kill_i;

`ifdef MULTDIV_CTRL_RESULT_CACHE_EN
  ibex_multdiv_result_cache u_result_cache (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fill_i       (capture),
    .fill_key_i   ({op_q, sm_q, a_q, b_q}),
    .fill_result_i(md_result_i),
    .lookup_key_i ({req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i}),
    .hit_o        (cache_hit),
    .hit_result_o (cache_result)
  );
`else
  assign cache_hit    = 1'b0;
  assign cache_result = 32'd0;
`endif

  // Next-state logic for the issue/response handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_CTRL_IDLE: begin
        if (accept) begin
          state_d = cache_hit ? MD_CTRL_RESP : MD_CTRL_BUSY;
        end else begin
          state_d = MD_CTRL_IDLE;
        end
      end
      MD_CTRL_BUSY: begin
        if (md_valid_i) begin
          state_d = kill_i ? MD_CTRL_IDLE : MD_CTRL_RESP;
        end else if (kill_i) begin
          state_d = MD_CTRL_DRAIN;
        end else begin
          state_d = MD_CTRL_BUSY;
        end
      end
      // The unit keeps its FSM state with enable low, so run it to completion.
      MD_CTRL_DRAIN: begin
        if (md_valid_i) begin
          state_d = MD_CTRL_IDLE;
        end else begin
          state_d = MD_CTRL_DRAIN;
        end
      end
      MD_CTRL_RESP: begin
        if (kill_i || rsp_ready_i) begin
          state_d = MD_CTRL_IDLE;
        end else begin
          state_d = MD_CTRL_RESP;
        end
      end
      default: state_d = MD_CTRL_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MD_CTRL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand/mode registers, held from accept until the next accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q <= MD_OP_MULL;
      sm_q <= 2'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (accept) begin
      op_q <= md_op_e'(req_operator_i);
      sm_q <= req_signed_mode_i;
      a_q  <= req_op_a_i;
      b_q  <= req_op_b_i;
    end else begin
      op_q <= op_q;
      sm_q <= sm_q;
      a_q  <= a_q;
      b_q  <= b_q;
    end
  end

  // Response register: loaded from the unit or from a cache hit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= 32'd0;
    end else if (capture) begin
      result_q <= md_result_i;
    end else if (accept && cache_hit) begin
      result_q <= cache_result;
    end else begin
      result_q <= result_q;
    end
  end

  assign md_en            = (state_q == MD_CTRL_BUSY) | (state_q == MD_CTRL_DRAIN);
  assign md_div_en_o      = md_en & md_is_div(op_q);
  assign md_mult_en_o     = md_en & ~md_is_div(op_q);
  assign md_operator_o    = op_q;
  assign md_signed_mode_o = sm_q;
  assign md_op_a_o        = a_q;
  assign md_op_b_o        = b_q;
  assign req_ready_o      = (state_q == MD_CTRL_IDLE);
  assign rsp_valid_o      = (state_q == MD_CTRL_RESP);
  assign rsp_result_o     = result_q;
  assign busy_o           = (state_q != MD_CTRL_IDLE);

endmodule

// File: doc/ibex_multdiv_ctrl.md
# ibex_multdiv_ctrl

Issue/response controller between the ID/EX issue logic and `ibex_multdiv_fast`. It accepts one M-extension request through a valid/ready handshake and registers the operands. It holds the multiplier or divider enable until the unit signals valid, then captures the result and presents it to writeback through a valid/ready handshake. On a pipeline kill it drains the unit safely, because `ibex_multdiv_fast` keeps its internal FSM state while its enable is low.

## Interface
Parameters: none.

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  controller can accept a request
- req_operator_i  in  2  md_op_e: MULL=0, MULH=1, DIV=2, REM=3
- req_signed_mode_i  in  2  bit0 = op_a signed, bit1 = op_b signed
- req_op_a_i  in  32  operand A
- req_op_b_i  in  32  operand B
- kill_i  in  1  flush of the instruction in EX
- md_mult_en_o  out  1  to multdiv mult_en_i
- md_div_en_o  out  1  to multdiv div_en_i
- md_operator_o  out  2  registered operator
- md_signed_mode_o  out  2  registered signed mode
- md_op_a_o  out  32  registered operand A
- md_op_b_o  out  32  registered operand B
- md_valid_i  in  1  multdiv valid_o
- md_result_i  in  32  multdiv multdiv_result_o, sampled only when md_valid_i is high
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  writeback accepts the result
- rsp_result_o  out  32  result register
- busy_o  out  1  state != IDLE

## Operation
- The operation class is derived from the operator: is_div = operator[1].
- FSM states:
  - IDLE: req_ready_o = 1. Accept = req_valid_i & !kill_i. On accept, latch operator, signed mode and operands; go to BUSY, or to RESP on a cache hit.
  - BUSY:
    - Assert md_div_en_o if is_div, else md_mult_en_o.
    - md_valid_i & !kill_i: capture md_result_i into rsp_result_o, go to RESP.
    - md_valid_i & kill_i: discard the result, go to IDLE.
    - kill_i without md_valid_i: go to DRAIN.
  - DRAIN: keep the same enable asserted. On md_valid_i, go to IDLE without producing a response. kill_i has no effect.
  - RESP: rsp_valid_o = 1. rsp_ready_i → IDLE. kill_i → IDLE with the response dropped; kill has priority over rsp_ready_i.
- The enable stays asserted in the cycle md_valid_i is high, so the multdiv FSM returns to its idle state.
- Enables are never asserted in IDLE or RESP. md_mult_en_o and md_div_en_o are never high together.
- md_* operand and mode outputs are registers. They are stable from the cycle after accept until the state returns to IDLE.
- rsp_result_o holds its value until the next capture.
- Illegal state encoding recovers to IDLE.

## Timing
- Reset values: every output is 0 except req_ready_o, which is 1. State is IDLE.
- Accept in cycle 0 → enable high from cycle 1. md_valid_i in cycle N → rsp_valid_o in cycle N+1.
- With ibex_multdiv_fast:
  - MULL: md_valid_i in the 3rd enabled cycle.
  - MULH: 4th enabled cycle.
  - DIV/REM: 37th enabled cycle.
  - Divide by zero: 2nd enabled cycle.
- Issue throughput: at most one outstanding request. The next request is accepted no earlier than the cycle after the response handshake.
- rsp_valid_o stays high and rsp_result_o stays stable until rsp_ready_i, unless kill_i is asserted.
- Reset mid-operation: everything returns to reset values immediately. ibex_multdiv_fast must share rst_ni.

## Configuration
- `MULTDIV_CTRL_RESULT_CACHE_EN` defined:
  - A single-entry cache holds key {operator, signed_mode, op_a, op_b} (68 bits), the 32-bit result and a valid bit.
  - Filled on every response captured in BUSY. Killed or drained results are never stored.
  - An accept that hits the cache goes directly to RESP in cycle 1 with the cached result. No enable is asserted.
  - The valid bit is cleared on reset only.
- Undefined: no cache storage. Every request goes through BUSY.

## Structure
- ibex_pkg: md_op_e, and the ctrl state typedef md_ctrl_state_e (IDLE, BUSY, DRAIN, RESP).
- One sub-module, ibex_multdiv_result_cache, holds the key/result/valid storage and hit compare. It is instantiated only under the macro.

## Test plan
- MULL A=0x0000_0007, B=0x0000_0006. Model asserts md_valid_i on the 3rd enabled cycle with 0x2A → rsp_valid_o in cycle 4, rsp_result_o = 0x2A, req_ready_o low during cycles 1–4.
- DIV signed, A=0xFFFF_FFF9 (−7), B=2. Model valid at the 37th cycle with 0xFFFF_FFFD → response 0xFFFF_FFFD, md_div_en_o high for exactly 37 cycles.
- kill_i in BUSY cycle 10 of a DIV → DRAIN, md_div_en_o held until md_valid_i, no rsp_valid_o, then IDLE with req_ready_o = 1.
- rsp_ready_i held low 5 cycles → rsp_valid_o and rsp_result_o stable for all 5; a new req_valid_i is not accepted until after the handshake.
- kill_i together with req_valid_i in IDLE → no accept, enables stay 0. kill_i in RESP → response dropped.
- With macro: repeat MULH 0x1234_5678 × 0x9ABC_DEF0 unsigned → second request gives rsp_valid_o in cycle 1 with the identical result, no enable asserted. A different op_b misses and goes to BUSY.
